fetch_queue: RTL

//   Instruction prefetch queue between instruction_memory and the decode stage of VR16.

---
 rtl/fetch_queue_pkg.sv | 8 +
 rtl/fetch_queue_mem.sv | 24 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared VR16 widths and encodings; fetch_queue takes its parameter defaults from here.
package fetch_queue_pkg;

  localparam int          VR16_INSN_WIDTH = 16;
  localparam int          VR16_ADDR_WIDTH = 16;
  localparam logic [15:0] VR16_NOP        = 16'h0000;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for fetch_queue: DEPTH x WIDTH register array.
// Writes are synchronous and reads are asynchronous, so the head entry is visible the cycle after it is written.
module fetch_queue_mem #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// VR16 instruction prefetch queue between instruction memory and decode, with flush on a taken jump or return.
// Defining FETCH_QUEUE_BYPASS_EN lets a word pass straight through when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int INSN_WIDTH = VR16_INSN_WIDTH,
  parameter  int ADDR_WIDTH = VR16_ADDR_WIDTH,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  input  logic [INSN_WIDTH-1:0] i_in_instruction,
  input  logic [ADDR_WIDTH-1:0] i_in_pc,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [INSN_WIDTH-1:0] o_out_instruction,
  output logic [ADDR_WIDTH-1:0] o_out_pc,
  input  logic                  i_out_ready,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  logic [PW-1:0]                    r_wr_ptr;
  logic [PW-1:0]                    r_rd_ptr;
  logic [CW-1:0]                    r_count;
  logic                             w_empty;
  logic                             w_full;
  logic                             w_push;
  logic                             w_bypass;
  logic                             w_out_valid;
  logic                             w_wr;
  logic                             w_rd;
  logic [ADDR_WIDTH+INSN_WIDTH-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_in_valid & ~w_full;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming word; it is stored only if decode is not taking it.
  assign w_bypass    = w_empty & i_in_valid & ~i_flush;
  assign w_out_valid = (~w_empty | i_in_valid) & ~i_flush;
  assign w_wr        = w_push & ~(w_bypass & i_out_ready) & ~i_flush;
`else
  assign w_bypass    = 1'b0;
  assign w_out_valid = ~w_empty;
  assign w_wr        = w_push & ~i_flush;
`endif

  assign w_rd = ~w_empty & i_out_ready;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH + INSN_WIDTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({i_in_pc, i_in_instruction}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero whenever nothing valid sits there.
  always_comb begin
    o_out_pc          = '0;
    o_out_instruction = '0;
    if (!w_empty) begin
      {o_out_pc, o_out_instruction} = w_rd_data;
    end else if (w_bypass) begin
      o_out_pc          = i_in_pc;
      o_out_instruction = i_in_instruction;
    end
  end

  assign o_in_ready  = ~w_full;
  assign o_out_valid = w_out_valid;
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;

endmodule
